contar_autos_multi: RTL and testbench

// Multi-gate parking occupancy counter. It replaces the single-gate counter.

---
 rtl/contar_autos_pkg.sv | 26 ++
 rtl/contar_autos_multi_sincronizador_flanco.sv | 29 ++
 rtl/contar_autos_multi.sv | 93 +++++++++
 tb/tb_contar_autos_multi.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/contar_autos_pkg.sv
// Shared constants and the ordered accept-mask helper for the parking occupancy counter.
package contar_autos_pkg;

    localparam int CAPACIDAD_DEF = 100;
    localparam int T_BARRERA_DEF = 16;
    localparam int MAX_PUERTAS   = 8;

    // Grants up to 'limit' requests, lowest gate index first.
    function automatic logic [MAX_PUERTAS-1:0] popcount_lim(
        input logic [MAX_PUERTAS-1:0] vec,
        input int unsigned            limit
    );
        logic [MAX_PUERTAS-1:0] mask;
        int unsigned            cnt;
        mask = '0;
        cnt  = 0;
        for (int i = 0; i < MAX_PUERTAS; i++) begin
            if (vec[i] && (cnt < limit)) begin
                mask[i] = 1'b1;
                cnt++;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/contar_autos_multi_sincronizador_flanco.sv
// Two-flop synchroniser with rising-edge detect; events are masked until the
// pipeline holds a real post-reset sample, so a level already high at release is ignored.
module sincronizador_flanco (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic evento
);

    logic       s1, s2, prev;
    logic [2:0] vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            vld  <= 3'b000;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
            vld  <= {vld[1:0], 1'b1};
        end
    end

    assign evento = s2 & ~prev & vld[2];

endmodule

// File: rtl/contar_autos_multi.sv
// Multi-gate parking occupancy counter: per-cycle exit/entry arbitration against
// capacity, registered status outputs and retriggerable per-gate barrier timers.
module contar_autos_multi
    import contar_autos_pkg::*;
#(
    parameter int  N_PUERTAS = 4,
    parameter int  CAPACIDAD = CAPACIDAD_DEF,
    parameter int  T_BARRERA = T_BARRERA_DEF,
    localparam int W         = $clog2(CAPACIDAD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PUERTAS-1:0] entrada,
    input  logic [N_PUERTAS-1:0] salida,
    output logic [W-1:0]         espacio,
    output logic [W-1:0]         libres,
    output logic                 lleno,
    output logic                 vacio,
    output logic [N_PUERTAS-1:0] abrir,
    output logic [N_PUERTAS-1:0] rechazo,
    output logic [N_PUERTAS-1:0] error_salida
);

    localparam int TW = $clog2(T_BARRERA + 1);
    localparam int WX = W + 4;

    logic [N_PUERTAS-1:0]   ev_in, ev_out;
    logic [MAX_PUERTAS-1:0] vin8, vout8, acc_in8, acc_out8;
    logic [WX-1:0]          n_in, n_out, room, esp_next;
    logic [TW-1:0]          timer [N_PUERTAS];

    for (genvar g = 0; g < N_PUERTAS; g++) begin : g_sync
        sincronizador_flanco u_sync_in (
            .clk    (clk),
            .reset  (reset),
            .d      (entrada[g]),
            .evento (ev_in[g])
        );
        sincronizador_flanco u_sync_out (
            .clk    (clk),
            .reset  (reset),
            .d      (salida[g]),
            .evento (ev_out[g])
        );
    end

    // Exits are granted first so that a car leaving frees room for an entry in the same cycle.
    always_comb begin
        vin8                  = '0;
        vout8                 = '0;
        vin8[N_PUERTAS-1:0]   = ev_in;
        vout8[N_PUERTAS-1:0]  = ev_out;
        acc_out8 = popcount_lim(vout8, 32'(espacio));
        n_out    = '0;
        for (int i = 0; i < MAX_PUERTAS; i++) n_out += WX'(acc_out8[i]);
        room     = WX'(CAPACIDAD) - WX'(espacio) + n_out;
        acc_in8  = popcount_lim(vin8, 32'(room));
        n_in     = '0;
        for (int i = 0; i < MAX_PUERTAS; i++) n_in += WX'(acc_in8[i]);
        esp_next = WX'(espacio) - n_out + n_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            espacio      <= '0;
            libres       <= W'(CAPACIDAD);
            lleno        <= 1'b0;
            vacio        <= 1'b1;
            rechazo      <= '0;
            error_salida <= '0;
            for (int i = 0; i < N_PUERTAS; i++) timer[i] <= '0;
        end else begin
            espacio      <= W'(esp_next);
            libres       <= W'(WX'(CAPACIDAD) - esp_next);
            lleno        <= (esp_next == WX'(CAPACIDAD));
            vacio        <= (esp_next == '0);
            rechazo      <= ev_in  & ~acc_in8[N_PUERTAS-1:0];
            error_salida <= ev_out & ~acc_out8[N_PUERTAS-1:0];
            for (int i = 0; i < N_PUERTAS; i++) begin
                if (acc_in8[i])
                    timer[i] <= TW'(T_BARRERA);
                else if (timer[i] != '0)
                    timer[i] <= timer[i] - 1'b1;
            end
        end
    end

    always_comb begin
        abrir = '0;
        for (int i = 0; i < N_PUERTAS; i++) abrir[i] = (timer[i] != '0);
    end

endmodule

// File: tb/tb_contar_autos_multi.sv
// Directed bench for contar_autos_multi with four gates and a capacity of four cars.
module tb_contar_autos_multi;

    localparam int N   = 4;
    localparam int CAP = 4;
    localparam int TB  = 16;
    localparam int W   = $clog2(CAP + 1);

    logic         clk;
    logic         reset;
    logic [N-1:0] entrada, salida;
    logic [W-1:0] espacio, libres;
    logic         lleno, vacio;
    logic [N-1:0] abrir, rechazo, error_salida;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    contar_autos_multi #(
        .N_PUERTAS (N),
        .CAPACIDAD (CAP),
        .T_BARRERA (TB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entrada      (entrada),
        .salida       (salida),
        .espacio      (espacio),
        .libres       (libres),
        .lleno        (lleno),
        .vacio        (vacio),
        .abrir        (abrir),
        .rechazo      (rechazo),
        .error_salida (error_salida)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_espacio"}, espacio, 0);
        check({tag, "_libres"},  libres,  CAP);
        check({tag, "_lleno"},   lleno,   0);
        check({tag, "_vacio"},   vacio,   1);
        check({tag, "_abrir"},   abrir,   0);
        check({tag, "_rechazo"}, rechazo, 0);
        check({tag, "_error"},   error_salida, 0);
    endtask

    // Raise the given sensors together, check the k+2 result, the pulse width, then release.
    task automatic apply(input string tag, input logic [N-1:0] ein, input logic [N-1:0] eout,
                         input int exp_esp, input logic [N-1:0] exp_rech,
                         input logic [N-1:0] exp_err, input logic [N-1:0] care_ab,
                         input logic [N-1:0] exp_ab);
        logic [W-1:0] e;
        exp_q.push_back(W'(exp_esp));
        entrada = ein;
        salida  = eout;
        tick(3);
        e = exp_q.pop_front();
        check({tag, "_espacio"}, espacio, e);
        check({tag, "_libres"},  libres,  CAP - exp_esp);
        check({tag, "_lleno"},   lleno,   (exp_esp == CAP));
        check({tag, "_vacio"},   vacio,   (exp_esp == 0));
        check({tag, "_rechazo"}, rechazo, exp_rech);
        check({tag, "_error"},   error_salida, exp_err);
        check({tag, "_abrir"},   abrir & care_ab, exp_ab);
        tick(1);
        check({tag, "_rechazo_end"}, rechazo, 0);
        check({tag, "_error_end"},   error_salida, 0);
        check({tag, "_espacio_hold"}, espacio, e);
        entrada = '0;
        salida  = '0;
        tick(3);
    endtask

    initial begin
        int cnt;
        entrada = '0;
        salida  = '0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        tick(3);
        check_reset_values("rst");
        reset = 1'b1;
        tick(4);

        // single entry: latency and barrier length
        entrada = 4'b0001;
        tick(2);
        check("t1_k1_espacio", espacio, 0);
        check("t1_k1_abrir", abrir[0], 0);
        tick(1);
        check("t1_k2_espacio", espacio, 1);
        check("t1_k2_vacio", vacio, 0);
        cnt = 0;
        for (int c = 0; c < 40 && abrir[0]; c++) begin
            cnt++;
            tick(1);
        end
        check("t1_abrir_len", cnt, TB);
        check("t1_espacio_hold", espacio, 1);
        entrada = '0;
        tick(3);

        // fill to capacity, then a refused entry
        apply("fill2", 4'b0010, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        apply("fill3", 4'b0001, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        apply("fill4", 4'b0010, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        apply("t2_rej", 4'b0100, 4'b0000, 4, 4'b0100, 4'b0000, 4'b0100, 4'b0000);

        // one slot left, four simultaneous entries
        apply("to3", 4'b0000, 4'b0001, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        apply("t3", 4'b1111, 4'b0000, 4, 4'b1110, 4'b0000, 4'b1101, 4'b0001);

        // full: exit and entry in the same cycle
        apply("t4", 4'b1000, 4'b0010, 4, 4'b0000, 4'b0000, 4'b1000, 4'b1000);

        // exits against an empty or nearly empty lot
        apply("drain", 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        apply("t5a", 4'b0000, 4'b0011, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
        apply("t5_one", 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        apply("t5b", 4'b0000, 4'b0011, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        // held sensor, then reset mid-count with sensors still high
        entrada = 4'b0010;
        tick(50);
        check("t6_held_espacio", espacio, 1);
        entrada = 4'b1010;
        tick(3);
        check("t6_second_espacio", espacio, 2);
        check("t6_second_abrir", abrir[3], 1);
        reset = 1'b0;
        #1;
        check_reset_values("t6_rst");
        tick(2);
        reset = 1'b1;
        tick(10);
        check("t6_rel_espacio", espacio, 0);
        check("t6_rel_abrir", abrir, 0);
        check("t6_rel_vacio", vacio, 1);
        entrada = '0;
        tick(3);
        entrada = 4'b0010;
        tick(3);
        check("t6_after_espacio", espacio, 1);
        entrada = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
